// File: rtl/nco_step_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_step_sched_pkg
// Description : Shared constants, voice-index width helper and sequencer
//               state encoding for the polyphonic NCO step scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_step_sched_pkg;

  localparam int NOTE_W = 7;   // MIDI note number width / step ROM address
  localparam int STEP_W = 16;  // step ROM data width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Ceiling log2, used for the voice-index width (VOICES >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nco_voice_regs.sv
`default_nettype none
// ============================================================================
// Module      : nco_voice_regs
// Description : Per-voice note/gate/phase register file. One write port for
//               note/gate updates, one read port for sweep issue and one
//               read-modify-write port for the phase accumulator stage.
//               Optional macro NCO_PHASE_RESET_EN adds per-voice restart
//               flags that zero the phase on the first update after note-on.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_voice_regs
  import nco_step_sched_pkg::*;
#(
  parameter  int VOICES = 8,
  parameter  int ACC_W  = 16,
  localparam int VW     = clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  // note/gate write port
  input  logic              wr_en,
  input  logic [VW-1:0]     wr_voice,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_gate,
  // issue read port
  input  logic [VW-1:0]     rd_voice,
  output logic [NOTE_W-1:0] rd_note,
  output logic              rd_gate,
  // phase read-modify-write port
  input  logic              upd_en,
  input  logic [VW-1:0]     upd_voice,
  input  logic              upd_gate,
  input  logic [STEP_W-1:0] upd_step,
  output logic [ACC_W-1:0]  upd_phase
);

  logic [NOTE_W-1:0] note_q  [VOICES];
  logic [NOTE_W-1:0] note_d  [VOICES];
  logic [VOICES-1:0] gate_q;
  logic [VOICES-1:0] gate_d;
  logic [ACC_W-1:0]  phase_q [VOICES];
  logic [ACC_W-1:0]  phase_d [VOICES];
  logic [ACC_W-1:0]  base_phase;

  // Reads see the registered value, so a write in the issue cycle is not seen.
  assign rd_note = note_q[rd_voice];
  assign rd_gate = gate_q[rd_voice];

  // Note/gate write: takes effect the cycle after the strobe.
  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    if (wr_en) begin
      note_d[wr_voice] = wr_note;
      gate_d[wr_voice] = wr_gate;
    end
  end

`ifdef NCO_PHASE_RESET_EN
  logic [VOICES-1:0] restart_q;
  logic [VOICES-1:0] restart_d;

  // Restart flag: cleared by the voice's update, set by a gate 0->1 write
  // (a set in the same cycle as the update survives, as it is a newer note-on).
  always_comb begin
    restart_d = restart_q;
    if (upd_en) begin
      restart_d[upd_voice] = 1'b0;
    end
    if (wr_en && !gate_q[wr_voice] && wr_gate) begin
      restart_d[wr_voice] = 1'b1;
    end
  end

  // Restart flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      restart_q <= '0;
    end else begin
      restart_q <= restart_d;
    end
  end

  assign base_phase = restart_q[upd_voice] ? '0 : phase_q[upd_voice];
`else
  assign base_phase = phase_q[upd_voice];
`endif

  // Phase accumulate: wrapping add of the zero-extended step when gated on.
  always_comb begin
    phase_d   = phase_q;
    upd_phase = upd_gate ? (base_phase + ACC_W'(upd_step)) : base_phase;
    if (upd_en) begin
      phase_d[upd_voice] = upd_phase;
    end
  end

  // Register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_q  <= '{default: '0};
      gate_q  <= '0;
      phase_q <= '{default: '0};
    end else begin
      note_q  <= note_d;
      gate_q  <= gate_d;
      phase_q <= phase_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nco_step_sched.sv
`default_nettype none
// ============================================================================
// Module      : nco_step_sched
// Description : Time-multiplexed phase-accumulator sequencer. Each sample
//               tick sweeps all voices through a shared external step ROM
//               (1-cycle registered read) and streams updated phases out.
//               Optional macro NCO_PHASE_RESET_EN: restart phase at note-on.
// Revision    : 1.0 - initial release
// ============================================================================
module nco_step_sched
  import nco_step_sched_pkg::*;
#(
  parameter  int VOICES = 8,
  parameter  int ACC_W  = 16,
  localparam int VW     = clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              note_we,
  input  logic [VW-1:0]     note_voice,
  input  logic [NOTE_W-1:0] note_num,
  input  logic              note_gate,
  output logic              rom_ce,
  output logic [NOTE_W-1:0] rom_a,
  input  logic [STEP_W-1:0] rom_d,
  output logic              phase_valid,
  output logic [VW-1:0]     phase_voice,
  output logic [ACC_W-1:0]  phase,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun
);

  localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);

  // sweep control
  state_e            state_q, state_d;
  logic [VW-1:0]     v_q, v_d;
  logic              drain_q, drain_d;
  logic              overrun_q, overrun_d;
  logic              issue;
  // rom address hold
  logic [NOTE_W-1:0] rom_a_q, rom_a_d;
  logic [NOTE_W-1:0] rd_note;
  logic              rd_gate;
  // stage 1 (ROM read in flight)
  logic              valid1_q, valid1_d;
  logic [VW-1:0]     v1_q, v1_d;
  logic              gate1_q, gate1_d;
  logic              last1_q, last1_d;
  // stage 2 outputs
  logic              phase_valid_q, phase_valid_d;
  logic [VW-1:0]     phase_voice_q, phase_voice_d;
  logic [ACC_W-1:0]  phase_out_q, phase_out_d;
  logic              frame_done_q, frame_done_d;
  logic [ACC_W-1:0]  upd_phase;

  nco_voice_regs #(
    .VOICES (VOICES),
    .ACC_W  (ACC_W)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (note_we),
    .wr_voice  (note_voice),
    .wr_note   (note_num),
    .wr_gate   (note_gate),
    .rd_voice  (v_q),
    .rd_note   (rd_note),
    .rd_gate   (rd_gate),
    .upd_en    (valid1_q),
    .upd_voice (v1_q),
    .upd_gate  (gate1_q),
    .upd_step  (rom_d),
    .upd_phase (upd_phase)
  );

  // Sweep FSM: issue one voice per cycle in RUN, then two DRAIN cycles.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    drain_d   = drain_q;
    overrun_d = overrun_q;
    issue     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          v_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        issue = 1'b1;
        if (sample_tick) overrun_d = 1'b1;
        v_d = v_q + VW'(1);
        if (v_q == LAST_V) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (sample_tick) overrun_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ROM request and stage-1 pipe: voice, gate and last-voice marker follow the read.
  always_comb begin
    rom_a    = issue ? rd_note : rom_a_q;
    rom_a_d  = rom_a;
    valid1_d = issue;
    v1_d     = v_q;
    gate1_d  = rd_gate;
    last1_d  = issue && (v_q == LAST_V);
  end

  // Stage 2: register the accumulated phase; voice/phase hold when idle.
  always_comb begin
    phase_valid_d = valid1_q;
    phase_voice_d = valid1_q ? v1_q : phase_voice_q;
    phase_out_d   = valid1_q ? upd_phase : phase_out_q;
    frame_done_d  = valid1_q && last1_q;
  end

  // Control and pipeline registers; reset aborts any sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      v_q           <= '0;
      drain_q       <= 1'b0;
      overrun_q     <= 1'b0;
      rom_a_q       <= '0;
      valid1_q      <= 1'b0;
      v1_q          <= '0;
      gate1_q       <= 1'b0;
      last1_q       <= 1'b0;
      phase_valid_q <= 1'b0;
      phase_voice_q <= '0;
      phase_out_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      v_q           <= v_d;
      drain_q       <= drain_d;
      overrun_q     <= overrun_d;
      rom_a_q       <= rom_a_d;
      valid1_q      <= valid1_d;
      v1_q          <= v1_d;
      gate1_q       <= gate1_d;
      last1_q       <= last1_d;
      phase_valid_q <= phase_valid_d;
      phase_voice_q <= phase_voice_d;
      phase_out_q   <= phase_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign rom_ce      = issue;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign phase_valid = phase_valid_q;
  assign phase_voice = phase_voice_q;
  assign phase       = phase_out_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire
